fp_minmax_clamp: RTL and testbench

Parametrised min/max/clamp unit for the fcore ALU, the successor to the two-operand saturator. It supports four modes: min, max, two-sided clamp against independent bounds, and symmetric magnitude clamp. Comparison uses either IEEE-754 total order or signed integer order, selected by a parameter. The block sits beside the other ALU units on the shared operation stream, accepts one operation per cycle, and returns a tagged result after a fixed, parametrised latency.

---
 rtl/fp_minmax_clamp.sv | 196 +++++++++++++++++++
 tb/tb_fp_minmax_clamp.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_minmax_clamp.sv
// ============================================================================
// fp_minmax_clamp : pipelined min/max/clamp unit, IEEE-754 or signed ordering
// Revision 1.0
// ============================================================================
`default_nettype none

module fp_minmax_clamp #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DEST_WIDTH     = 4,
  parameter int SELECTION_DEST = 6,
  parameter int PIPELINE_DEPTH = 5,
  parameter bit FP_MODE        = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     operand_a_i,
  input  logic [DATA_WIDTH-1:0]     operand_b_i,
  input  logic [DATA_WIDTH-1:0]     operand_c_i,
  input  logic [1:0]                operation_data_i,
  input  logic [DEST_WIDTH-1:0]     operation_dest_i,
  input  logic [REG_ADDR_WIDTH-1:0] operation_user_i,
  input  logic                      operation_valid_i,
  output logic                      operation_ready_o,
  output logic [DATA_WIDTH-1:0]     result_data_o,
  output logic [REG_ADDR_WIDTH-1:0] result_user_o,
  output logic [DEST_WIDTH-1:0]     result_dest_o,
  output logic                      result_valid_o,
  input  logic                      result_ready_i,
  output logic                      clamp_hit_o
);

  localparam int N_STAGES  = PIPELINE_DEPTH - 2;
  localparam int EXP_WIDTH = (DATA_WIDTH == 64) ? 11 : (DATA_WIDTH == 16) ? 5 : 8;
  localparam int MAN_WIDTH = DATA_WIDTH - 1 - EXP_WIDTH;
  localparam logic [DATA_WIDTH-1:0] SIGN_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MAX_POS   = ~SIGN_MASK;
  localparam logic [1:0] MODE_MIN = 2'd0;
  localparam logic [1:0] MODE_ABS = 2'd3;

  // Unsigned-comparable key: FP total order, or signed order via sign flip.
  function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] v);
    if (FP_MODE && v[DATA_WIDTH-1]) return ~v;
    return v ^ SIGN_MASK;
  endfunction

  function automatic logic is_nan(input logic [DATA_WIDTH-1:0] v);
    return FP_MODE && (&v[DATA_WIDTH-2 -: EXP_WIDTH]) && (|v[MAN_WIDTH-1:0]);
  endfunction

  logic unused_ready;
  assign unused_ready      = result_ready_i;
  assign operation_ready_o = 1'b1;
  assign result_dest_o     = '0;

  logic                  accept;
  logic [DATA_WIDTH-1:0] mag_d, neg_mag_d, lo_d, hi_d;

  assign accept = operation_valid_i && (operation_dest_i == DEST_WIDTH'(SELECTION_DEST));

  // Abs-clamp rewrites the bounds to [-|b|, |b|] so stage 2 sees one clamp form.
  always_comb begin
    mag_d = operand_b_i & MAX_POS;
    if (!FP_MODE) begin
      if (operand_b_i == SIGN_MASK)      mag_d = MAX_POS;
      else if (operand_b_i[DATA_WIDTH-1]) mag_d = -operand_b_i;
      else                               mag_d = operand_b_i;
    end
    neg_mag_d = FP_MODE ? (mag_d | SIGN_MASK) : -mag_d;
    lo_d      = (operation_data_i == MODE_ABS) ? neg_mag_d : operand_b_i;
    hi_d      = (operation_data_i == MODE_ABS) ? mag_d     : operand_c_i;
  end

  logic                      s1_valid_q, s1_nan_a_q, s1_nan_lo_q;
  logic [1:0]                s1_mode_q;
  logic [REG_ADDR_WIDTH-1:0] s1_user_q;
  logic [DATA_WIDTH-1:0]     s1_a_q, s1_lo_q, s1_hi_q;
  logic [DATA_WIDTH-1:0]     s1_ka_q, s1_klo_q, s1_khi_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_nan_a_q  <= 1'b0;
      s1_nan_lo_q <= 1'b0;
      s1_mode_q   <= '0;
      s1_user_q   <= '0;
      s1_a_q      <= '0;
      s1_lo_q     <= '0;
      s1_hi_q     <= '0;
      s1_ka_q     <= '0;
      s1_klo_q    <= '0;
      s1_khi_q    <= '0;
    end else begin
      s1_valid_q  <= accept;
      s1_nan_a_q  <= is_nan(operand_a_i);
      s1_nan_lo_q <= is_nan(lo_d);
      s1_mode_q   <= operation_data_i;
      s1_user_q   <= operation_user_i;
      s1_a_q      <= operand_a_i;
      s1_lo_q     <= lo_d;
      s1_hi_q     <= hi_d;
      s1_ka_q     <= order_key(operand_a_i);
      s1_klo_q    <= order_key(lo_d);
      s1_khi_q    <= order_key(hi_d);
    end
  end

  logic                  lo_wins, s2_hit_d;
  logic [DATA_WIDTH-1:0] sel, ksel, s2_data_d;

  always_comb begin
    lo_wins   = (s1_mode_q == MODE_MIN) ? (s1_klo_q < s1_ka_q) : (s1_klo_q > s1_ka_q);
    sel       = lo_wins ? s1_lo_q  : s1_a_q;
    ksel      = lo_wins ? s1_klo_q : s1_ka_q;
    s2_data_d = sel;
    s2_hit_d  = 1'b0;
    if (s1_mode_q[1]) begin
      s2_data_d = (s1_khi_q < ksel) ? s1_hi_q : sel;
      s2_hit_d  = (s2_data_d != s1_a_q);
      if (s1_nan_a_q) begin
        s2_data_d = s1_lo_q;
        s2_hit_d  = 1'b1;
      end
    end else if (s1_nan_a_q || s1_nan_lo_q) begin
      s2_data_d = (s1_nan_a_q && !s1_nan_lo_q) ? s1_lo_q : s1_a_q;
    end
  end

  logic                      s2_valid_q, s2_hit_q;
  logic [DATA_WIDTH-1:0]     s2_data_q;
  logic [REG_ADDR_WIDTH-1:0] s2_user_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_data_q  <= '0;
      s2_user_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_hit_q   <= s1_valid_q & s2_hit_d;
      if (s1_valid_q) begin
        s2_data_q <= s2_data_d;
        s2_user_q <= s1_user_q;
      end
    end
  end

  generate
    if (N_STAGES == 0) begin : g_no_delay
      assign result_valid_o = s2_valid_q;
      assign result_data_o  = s2_data_q;
      assign result_user_o  = s2_user_q;
      assign clamp_hit_o    = s2_hit_q;
    end else begin : g_delay
      logic [N_STAGES-1:0]       valid_q, hit_q;
      logic [DATA_WIDTH-1:0]     data_q [N_STAGES];
      logic [REG_ADDR_WIDTH-1:0] user_q [N_STAGES];

      // Data/user only advance with a valid beat so the output holds between results.
      always_ff @(posedge clock) begin
        if (!reset) begin
          valid_q <= '0;
          hit_q   <= '0;
          for (int i = 0; i < N_STAGES; i++) begin
            data_q[i] <= '0;
            user_q[i] <= '0;
          end
        end else begin
          valid_q[0] <= s2_valid_q;
          hit_q[0]   <= s2_hit_q;
          if (s2_valid_q) begin
            data_q[0] <= s2_data_q;
            user_q[0] <= s2_user_q;
          end
          for (int i = 1; i < N_STAGES; i++) begin
            valid_q[i] <= valid_q[i-1];
            hit_q[i]   <= hit_q[i-1];
            if (valid_q[i-1]) begin
              data_q[i] <= data_q[i-1];
              user_q[i] <= user_q[i-1];
            end
          end
        end
      end

      assign result_valid_o = valid_q[N_STAGES-1];
      assign result_data_o  = data_q[N_STAGES-1];
      assign result_user_o  = user_q[N_STAGES-1];
      assign clamp_hit_o    = hit_q[N_STAGES-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fp_minmax_clamp.sv
// tb_fp_minmax_clamp : four instances (FP d5, INT d5, FP d2, FP d8) driven in lockstep
// and checked against an ordering model derived from sign/magnitude rules.
`default_nettype none

module tb_fp_minmax_clamp;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] op_a, op_b, op_c;
  logic [1:0]  op_mode;
  logic [3:0]  op_dest, op_user;
  logic        op_valid;

  logic [3:0][31:0] o_data;
  logic [3:0][3:0]  o_user, o_dest;
  logic [3:0]       o_valid, o_hit, o_ready;

  int total  = 0;
  int bad    = 0;
  int edge_n = 0;
  int n_ops  = 0;
  int rd [4] = '{0, 0, 0, 0};
  int          issue [512];
  logic [31:0] exp_d [512][2];
  logic        exp_h [512][2];
  logic [3:0]  exp_u [512];
  bit          canc  [4][512];

  always #5 clock = ~clock;
  always @(posedge clock) edge_n++;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int D = (g == 2) ? 2 : (g == 3) ? 8 : 5;
    localparam bit F = (g != 1);
    fp_minmax_clamp #(
      .DATA_WIDTH(32), .REG_ADDR_WIDTH(4), .DEST_WIDTH(4),
      .SELECTION_DEST(6), .PIPELINE_DEPTH(D), .FP_MODE(F)
    ) u_dut (
      .clock(clock), .reset(reset),
      .operand_a_i(op_a), .operand_b_i(op_b), .operand_c_i(op_c),
      .operation_data_i(op_mode), .operation_dest_i(op_dest),
      .operation_user_i(op_user), .operation_valid_i(op_valid),
      .operation_ready_o(o_ready[g]),
      .result_data_o(o_data[g]), .result_user_o(o_user[g]),
      .result_dest_o(o_dest[g]), .result_valid_o(o_valid[g]),
      .result_ready_i(1'b1), .clamp_hit_o(o_hit[g])
    );
  end

  function automatic int dep(input int k);
    return (k == 2) ? 2 : (k == 3) ? 8 : 5;
  endfunction

  function automatic int fp_of(input int k);
    return (k == 1) ? 0 : 1;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, expv);
    end
  endtask

  // Reference ordering written from value semantics, not from the key trick.
  function automatic bit is_nan(input bit fp, input logic [31:0] x);
    return fp && (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic bit less(input bit fp, input logic [31:0] x, input logic [31:0] y);
    if (!fp) return $signed(x) < $signed(y);
    if (x[31] != y[31]) return x[31];
    if (x[31]) return x[30:0] > y[30:0];
    return x[30:0] < y[30:0];
  endfunction

  task automatic model(input bit fp, input logic [1:0] m, input logic [31:0] a, b, c,
                       output logic [31:0] r, output logic h);
    logic [31:0] lo, hi, t;
    h = 1'b0;
    if (m < 2'd2) begin
      if (is_nan(fp, a) && !is_nan(fp, b))     r = b;
      else if (is_nan(fp, a) || is_nan(fp, b)) r = a;
      else if (m == 2'd0)                      r = less(fp, b, a) ? b : a;
      else                                     r = less(fp, a, b) ? b : a;
    end else begin
      if (m == 2'd2) begin
        lo = b;
        hi = c;
      end else if (fp) begin
        hi = {1'b0, b[30:0]};
        lo = {1'b1, b[30:0]};
      end else begin
        if (b == 32'h8000_0000)  hi = 32'h7FFF_FFFF;
        else if ($signed(b) < 0) hi = 32'd0 - b;
        else                     hi = b;
        lo = 32'd0 - hi;
      end
      if (is_nan(fp, a)) begin
        r = lo;
        h = 1'b1;
      end else begin
        t = less(fp, a, lo) ? lo : a;
        r = less(fp, hi, t) ? hi : t;
        h = (r != a);
      end
    end
  endtask

  // Drive at the current negedge; an op presented here is sampled at edge issue=edge_n+1.
  task automatic apply(input logic v, input logic [1:0] m, input logic [31:0] a, b, c,
                       input logic [3:0] dst, input logic [3:0] usr);
    logic [31:0] r;
    logic        h;
    op_valid = v; op_mode = m; op_a = a; op_b = b; op_c = c; op_dest = dst; op_user = usr;
    if (v && dst == 4'd6 && reset) begin
      model(1'b0, m, a, b, c, r, h);
      exp_d[n_ops][0] = r; exp_h[n_ops][0] = h;
      model(1'b1, m, a, b, c, r, h);
      exp_d[n_ops][1] = r; exp_h[n_ops][1] = h;
      exp_u[n_ops] = usr;
      issue[n_ops] = edge_n + 1;
      n_ops++;
    end
  endtask

  task automatic send(input logic v, input logic [1:0] m, input logic [31:0] a, b, c,
                      input logic [3:0] dst, input logic [3:0] usr);
    @(negedge clock);
    apply(v, m, a, b, c, dst, usr);
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 4'd0, 4'd0);
  endtask

  task automatic expect_fp(input logic [31:0] d, input logic h);
    exp_d[n_ops-1][1] = d; exp_h[n_ops-1][1] = h;
  endtask

  task automatic expect_int(input logic [31:0] d, input logic h);
    exp_d[n_ops-1][0] = d; exp_h[n_ops-1][0] = h;
  endtask

  // Reset sampled at edge R kills every result that would become visible at or after R.
  task automatic cancel_inflight();
    for (int k = 0; k < 4; k++)
      for (int i = rd[k]; i < n_ops; i++)
        if (issue[i] + dep(k) - 1 >= edge_n + 1) canc[k][i] = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_valid"}, k, 32'(o_valid[k]), 32'd0);
      chk({tag, "_data"},  k, o_data[k], 32'd0);
      chk({tag, "_user"},  k, 32'(o_user[k]), 32'd0);
      chk({tag, "_hit"},   k, 32'(o_hit[k]), 32'd0);
      chk({tag, "_dest"},  k, 32'(o_dest[k]), 32'd0);
    end
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       return {r[31], 8'hFF, r[22:1], 1'b1};
      1:       return {r[31], 31'd0};
      2:       return r[0] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      3:       return {r[31], 8'hFF, 23'd0};
      default: return r;
    endcase
  endfunction

  // A result sampled at edge issue+D is visible at the negedge just before that edge.
  always @(negedge clock) begin
    for (int k = 0; k < 4; k++) begin
      while (rd[k] < n_ops && canc[k][rd[k]]) rd[k]++;
      if (rd[k] < n_ops && issue[rd[k]] + dep(k) == edge_n + 1) begin
        chk("res_valid", k, 32'(o_valid[k]), 32'd1);
        chk("res_data",  k, o_data[k], exp_d[rd[k]][fp_of(k)]);
        chk("res_user",  k, 32'(o_user[k]), 32'(exp_u[rd[k]]));
        chk("res_hit",   k, 32'(o_hit[k]), 32'(exp_h[rd[k]][fp_of(k)]));
        chk("res_dest",  k, 32'(o_dest[k]), 32'd0);
        rd[k]++;
      end else begin
        chk("idle_valid", k, 32'(o_valid[k]), 32'd0);
        chk("idle_hit",   k, 32'(o_hit[k]), 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] a, b, c;
    logic [3:0]  dst;
    logic        v;
    int          pend;
    apply(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clock);
    chk_zero("reset_state");
    for (int k = 0; k < 4; k++) chk("ready", k, 32'(o_ready[k]), 32'd1);
    reset = 1'b1;

    // Directed vectors with hand-computed results.
    send(1'b1, 2'd0, 32'hBF80_0000, 32'hC000_0000, 32'd0, 4'd6, 4'h9); expect_fp(32'hC000_0000, 1'b0);
    send(1'b1, 2'd1, 32'hBF80_0000, 32'hC000_0000, 32'd0, 4'd6, 4'h9); expect_fp(32'hBF80_0000, 1'b0);
    send(1'b1, 2'd2, 32'h4040_0000, 32'hBF80_0000, 32'h4000_0000, 4'd6, 4'h1); expect_fp(32'h4000_0000, 1'b1);
    send(1'b1, 2'd2, 32'h3F00_0000, 32'hBF80_0000, 32'h4000_0000, 4'd6, 4'h2); expect_fp(32'h3F00_0000, 1'b0);
    send(1'b1, 2'd2, 32'h3F00_0000, 32'h4000_0000, 32'h3F80_0000, 4'd6, 4'h3); expect_fp(32'h3F80_0000, 1'b1);
    send(1'b1, 2'd3, 32'hC040_0000, 32'hC000_0000, 32'd0, 4'd6, 4'h4); expect_fp(32'hC000_0000, 1'b1);
    send(1'b1, 2'd3, 32'h8000_0000, 32'h8000_0000, 32'd0, 4'd6, 4'h5); expect_int(32'h8000_0001, 1'b1);
    send(1'b1, 2'd0, 32'h7FC0_0000, 32'h3F80_0000, 32'd0, 4'd6, 4'h6); expect_fp(32'h3F80_0000, 1'b0);
    send(1'b1, 2'd2, 32'h7FC0_0000, 32'hBF80_0000, 32'h4000_0000, 4'd6, 4'h7); expect_fp(32'hBF80_0000, 1'b1);
    idle(10);

    // Streaming: 8 back-to-back, then 8 interleaved with dest=5 traffic.
    send(1'b1, 2'd1, rnd_val(), rnd_val(), rnd_val(), 4'd5, 4'hF);
    for (int i = 0; i < 8; i++)
      send(1'b1, 2'(i % 4), rnd_val(), rnd_val(), rnd_val(), 4'd6, 4'(i));
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 2'(i % 4), rnd_val(), rnd_val(), rnd_val(), 4'd6, 4'(i));
      send(1'b1, 2'((i + 1) % 4), rnd_val(), rnd_val(), rnd_val(), 4'd5, 4'hE);
    end
    idle(10);

    // Randomized mix including equal operands and foreign dest values.
    for (int i = 0; i < 200; i++) begin
      a   = rnd_val();
      b   = ($urandom_range(0, 5) == 0) ? a : rnd_val();
      c   = rnd_val();
      v   = ($urandom_range(0, 7) != 0);
      dst = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd6;
      send(v, 2'($urandom_range(0, 3)), a, b, c, dst, 4'($urandom));
    end
    idle(10);

    // Reset two cycles after the first of three ops; the third is presented under reset.
    send(1'b1, 2'd2, 32'h4040_0000, 32'hBF80_0000, 32'h4000_0000, 4'd6, 4'hA);
    send(1'b1, 2'd3, 32'hC040_0000, 32'hC000_0000, 32'd0, 4'd6, 4'hB);
    @(negedge clock);
    reset = 1'b0;
    cancel_inflight();
    apply(1'b1, 2'd0, 32'hBF80_0000, 32'hC000_0000, 32'd0, 4'd6, 4'hC);
    @(negedge clock);
    chk_zero("in_reset");
    apply(1'b1, 2'd1, 32'h1234_5678, 32'h0000_0001, 32'd0, 4'd6, 4'hD);
    @(negedge clock);
    chk_zero("in_reset2");
    reset = 1'b1;
    apply(1'b1, 2'd1, 32'hBF80_0000, 32'hC000_0000, 32'd0, 4'd6, 4'h3);
    @(negedge clock);
    chk_zero("after_reset");
    apply(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 4'd0, 4'd0);
    idle(12);

    #1;
    for (int k = 0; k < 4; k++) begin
      pend = 0;
      for (int i = rd[k]; i < n_ops; i++) if (!canc[k][i]) pend++;
      chk("drain_pending", k, 32'(pend), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
